// File: rtl/exe_to_mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exe_to_mem_stage : execute-stage ALU with iterative MUL + E->M pipeline reg
// Optional macro   : MUL_RADIX4_EN (retire 2 multiplier bits per cycle)
// Revision         : 1.0
// ----------------------------------------------------------------------------
module exe_to_mem_stage #(
  parameter int bits = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] RD1E,
  input  logic [bits-1:0] RD2E,
  input  logic [bits-1:0] immExtE,
  input  logic [3:0]      WA3E,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            validE,
  input  logic            flushE,
  output logic            stallE,
  output logic [bits-1:0] ALUResultM,
  output logic [bits-1:0] WriteDataM,
  output logic [3:0]      WA3M,
  output logic [3:0]      FlagsM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            validM
);

  localparam int CW = $clog2(bits);
`ifdef MUL_RADIX4_EN
  localparam int            STEP     = 2;
  localparam logic [CW-1:0] LAST_CNT = CW'(bits/2 - 1);
`else
  localparam int            STEP     = 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(bits - 1);
`endif
  localparam logic [bits-1:0] WIDTH_V = bits'(bits);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [bits-1:0] mcand_q, mplier_q, acc_q;
  logic [bits-1:0] res_q, wd_q;
  logic [3:0]      wa_q, flags_q;
  logic            rw_q, mw_q, valid_q;

  logic [bits-1:0] srcb_w, result_w, pp_w;
  logic [bits:0]   sum_w;
  logic            is_sub_w, c_w, v_w;
  logic [3:0]      flags_w;
  logic            start_w, capture_w;

  always_comb begin
    srcb_w   = ALUSrcE ? immExtE : RD2E;
    is_sub_w = (ALUControlE == OP_SUB);
    sum_w    = {1'b0, RD1E} + {1'b0, (is_sub_w ? ~srcb_w : srcb_w)} + {{bits{1'b0}}, is_sub_w};
    c_w      = 1'b0;
    v_w      = 1'b0;
    result_w = '0;
    case (ALUControlE)
      OP_ADD, OP_SUB: begin
        result_w = sum_w[bits-1:0];
        c_w      = sum_w[bits];
        // effective B sign is inverted for SUB since B enters as ~B + 1
        v_w      = (RD1E[bits-1] == (srcb_w[bits-1] ^ is_sub_w)) &&
                   (sum_w[bits-1] != RD1E[bits-1]);
      end
      OP_AND:  result_w = RD1E & srcb_w;
      OP_ORR:  result_w = RD1E | srcb_w;
      OP_LSL:  result_w = (srcb_w >= WIDTH_V) ? '0 : (RD1E << srcb_w[CW-1:0]);
      OP_LSR:  result_w = (srcb_w >= WIDTH_V) ? '0 : (RD1E >> srcb_w[CW-1:0]);
      OP_MUL:  result_w = acc_q;
      default: result_w = srcb_w;
    endcase
    flags_w = {result_w[bits-1], ~|result_w, c_w, v_w};
  end

`ifdef MUL_RADIX4_EN
  always_comb begin
    case (mplier_q[1:0])
      2'd0:    pp_w = '0;
      2'd1:    pp_w = mcand_q;
      2'd2:    pp_w = mcand_q << 1;
      default: pp_w = mcand_q + (mcand_q << 1);
    endcase
  end
`else
  assign pp_w = mplier_q[0] ? mcand_q : '0;
`endif

  assign start_w   = (state_q == S_IDLE) && validE && !flushE && (ALUControlE == OP_MUL);
  assign capture_w = validE && !flushE &&
                     (((state_q == S_IDLE) && (ALUControlE != OP_MUL)) || (state_q == S_DONE));
  assign stallE    = !rst && (start_w || ((state_q == S_BUSY) && !flushE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      wd_q     <= '0;
      wa_q     <= '0;
      flags_q  <= '0;
      rw_q     <= 1'b0;
      mw_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_w) begin
          state_q  <= S_BUSY;
          mcand_q  <= RD1E;
          mplier_q <= srcb_w;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        S_BUSY: if (flushE) begin
          state_q <= S_IDLE;
        end else begin
          acc_q    <= acc_q + pp_w;
          mcand_q  <= mcand_q << STEP;
          mplier_q <= mplier_q >> STEP;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase

      // bubbles clear only the control bits; data fields keep their last value
      if (capture_w) begin
        res_q   <= result_w;
        wd_q    <= RD2E;
        wa_q    <= WA3E;
        flags_q <= flags_w;
        rw_q    <= RegWriteE;
        mw_q    <= MemWriteE;
        valid_q <= 1'b1;
      end else begin
        rw_q    <= 1'b0;
        mw_q    <= 1'b0;
        valid_q <= 1'b0;
      end
    end
  end

  assign ALUResultM = res_q;
  assign WriteDataM = wd_q;
  assign WA3M       = wa_q;
  assign FlagsM     = flags_q;
  assign RegWriteM  = rw_q;
  assign MemWriteM  = mw_q;
  assign validM     = valid_q;

endmodule
`default_nettype wire
